// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller
// Prescaled digit dwell, 1-entry update buffer swapped only at frame boundaries, leading-zero blanking.
module display_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  output logic        upd_ready,
  input  logic        lz_blank,
  output logic [3:0]  digit,
  output logic [3:0]  anode,
  output logic        frame_done
);

  typedef enum logic [1:0] {PH_D0, PH_D1, PH_D2, PH_D3} phase_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  phase_e           phase_q, phase_d;
  logic [15:0]      shown_q, shown_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             run_q, run_d;
  logic [3:0]       digit_q, digit_d;
  logic [3:0]       anode_q, anode_d;
  logic             frame_done_q, frame_done_d;

  logic             tick;
  logic             boundary;
  logic             accept;
  logic [3:0]       lead_zero;
  logic [3:0]       anode_sel;
  logic             blank;

  always_comb begin
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    shown_d      = shown_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    run_d        = enable;
    frame_done_d = 1'b0;
    digit_d      = 4'h0;
    anode_sel    = 4'b1111;

    tick     = (cnt_q == CNT_MAX);
    boundary = enable && run_q && tick && (phase_q == PH_D3);
    accept   = upd_valid && !pend_full_q;

    if (!enable) begin
      // Dark display has no frames to tear, so a pending value goes straight to shown.
      cnt_d   = '0;
      phase_d = PH_D0;
      if (pend_full_q) begin
        shown_d     = pend_q;
        pend_full_d = 1'b0;
      end
    end else if (!run_q) begin
      // First enabled edge lights D0 with cnt at 0, giving it a full dwell.
      cnt_d   = '0;
      phase_d = PH_D0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + CNT_ONE;
      if (tick) phase_d = phase_e'(phase_q + 2'd1);
      if (boundary) begin
        frame_done_d = 1'b1;
        if (pend_full_q) begin
          shown_d     = pend_q;
          pend_full_d = 1'b0;
        end
      end
    end

    // Only possible while the buffer is empty, so it never collides with a transfer.
    if (accept) begin
      pend_d      = upd_data;
      pend_full_d = 1'b1;
    end

    lead_zero[0] = (shown_d[15:12] == 4'h0);
    lead_zero[1] = lead_zero[0] && (shown_d[11:8] == 4'h0);
    lead_zero[2] = lead_zero[1] && (shown_d[7:4] == 4'h0);
    lead_zero[3] = 1'b0;

    case (phase_d)
      PH_D0: begin digit_d = shown_d[15:12]; anode_sel = 4'b0111; end
      PH_D1: begin digit_d = shown_d[11:8];  anode_sel = 4'b1011; end
      PH_D2: begin digit_d = shown_d[7:4];   anode_sel = 4'b1101; end
      default: begin digit_d = shown_d[3:0]; anode_sel = 4'b1110; end
    endcase

    blank   = lz_blank && lead_zero[phase_d];
    anode_d = (!enable || blank) ? 4'b1111 : anode_sel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      phase_q      <= PH_D0;
      shown_q      <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_full_q  <= 1'b0;
      run_q        <= 1'b0;
      digit_q      <= 4'h0;
      anode_q      <= 4'b1111;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      shown_q      <= shown_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      run_q        <= run_d;
      digit_q      <= digit_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign upd_ready  = !pend_full_q;
  assign digit      = digit_q;
  assign anode      = anode_q;
  assign frame_done = frame_done_q;

endmodule
